// File: rtl/bridge_arbiter_pkg.sv
// Shared definitions for the device-bus arbiter.
//   - Device window geometry: base address, stride between windows, window size,
//     and the offset where the read-only word starts.
//   - Arbiter FSM state type.
package bridge_arbiter_pkg;

    localparam logic [31:0] DEV_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] WIN_STRIDE   = 32'h0000_0010;
    localparam logic [31:0] WIN_SIZE     = 32'h0000_000C;
    localparam logic [31:0] RO_OFF       = 32'h0000_0008;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bridge_arbiter_if.sv
// Bus bundle around the arbiter: CPU bridge port, secondary master request and
// response channel, device-side bus, and the starve flag.
//   slave  : arbiter view (takes CPU/m2 requests and device read data, drives
//            device bus, responses and starve)
//   master : requester/device-model view (the mirror image)
interface bridge_arbiter_if #(
    parameter int NDEV = 2
);
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wd;
    logic               cpu_we;
    logic               cpu_re;
    logic [31:0]        cpu_rd;

    logic               m2_valid;
    logic               m2_ready;
    logic [31:0]        m2_addr;
    logic [31:0]        m2_wd;
    logic               m2_we;
    logic               m2_rvalid;
    logic [31:0]        m2_rdata;
    logic               m2_err;

    logic [31:0]        dev_addr;
    logic [31:0]        dev_wd;
    logic [NDEV-1:0]    dev_we;
    logic [NDEV*32-1:0] dev_rd;

    logic               starve;

    modport slave (
        input  cpu_addr, cpu_wd, cpu_we, cpu_re,
        output cpu_rd,
        input  m2_valid, m2_addr, m2_wd, m2_we,
        output m2_ready, m2_rvalid, m2_rdata, m2_err,
        output dev_addr, dev_wd, dev_we,
        input  dev_rd,
        output starve
    );

    modport master (
        output cpu_addr, cpu_wd, cpu_we, cpu_re,
        input  cpu_rd,
        output m2_valid, m2_addr, m2_wd, m2_we,
        input  m2_ready, m2_rvalid, m2_rdata, m2_err,
        input  dev_addr, dev_wd, dev_we,
        output dev_rd,
        input  starve
    );
endinterface

// File: rtl/bridge_arbiter_decode.sv
// Address decoder for the device windows.
//   i_addr       : byte address to decode
//   o_hit        : one-hot window hit (window i = [base_i, base_i + WIN_SIZE - 1])
//   o_ro_off     : address falls in the read-only word of its window
//   o_misaligned : address is not word aligned
module bridge_arbiter_decode
    import bridge_arbiter_pkg::*;
#(
    parameter int          NDEV     = 2,
    parameter logic [31:0] DEV_BASE = DEV_BASE_DEF
) (
    input  logic [31:0]     i_addr,
    output logic [NDEV-1:0] o_hit,
    output logic            o_ro_off,
    output logic            o_misaligned
);

    logic [31:0] w_off;

    always_comb begin
        o_hit    = '0;
        o_ro_off = 1'b0;
        w_off    = '0;
        for (int i = 0; i < NDEV; i++) begin
            // Unsigned subtraction: addresses below the base wrap high and miss.
            w_off = i_addr - (DEV_BASE + 32'(i) * WIN_STRIDE);
            if (w_off < WIN_SIZE) begin
                o_hit[i] = 1'b1;
                if (w_off >= RO_OFF) begin
                    o_ro_off = 1'b1;
                end
            end
        end
        o_misaligned = |i_addr[1:0];
    end

endmodule

// File: rtl/bridge_arbiter.sv
// Device-bus arbiter between the CPU bridge port and a secondary master.
// The CPU has absolute priority and passes through combinationally; the
// secondary master gets one buffered request that issues on the first cycle
// the CPU is not touching a device window.
//   i_clk : system clock
//   i_rst : asynchronous active-high reset
//   bus   : bridge_arbiter_if.slave (CPU port, m2 request/response, device bus, starve)
module bridge_arbiter
    import bridge_arbiter_pkg::*;
#(
    parameter int          NDEV         = 2,
    parameter logic [31:0] DEV_BASE     = DEV_BASE_DEF,
    parameter int          STARVE_LIMIT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    bridge_arbiter_if.slave    bus
);

    localparam int            CW    = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [NDEV-1:0] w_cpu_hit;
    logic            w_cpu_ro;
    logic            w_cpu_misal_unused;
    logic [NDEV-1:0] w_m2_hit;
    logic            w_m2_ro;
    logic            w_m2_misal;
    logic            w_cpu_active;
    logic            w_m2_bad;
    logic [31:0]     w_cpu_rd;
    logic [31:0]     w_hold_rd;
    logic [31:0]     w_dev_addr;
    logic [31:0]     w_dev_wd;
    logic [NDEV-1:0] w_dev_we;

    state_t          r_state;
    logic            r_ready;
    logic            r_rvalid;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic [31:0]     r_hold_addr;
    logic [31:0]     r_hold_wd;
    logic            r_hold_we;
    logic [NDEV-1:0] r_hold_hit;
    logic [CW-1:0]   r_cnt;
    logic            r_starve;

    bridge_arbiter_decode #(.NDEV(NDEV), .DEV_BASE(DEV_BASE)) u_cpu_dec (
        .i_addr       (bus.cpu_addr),
        .o_hit        (w_cpu_hit),
        .o_ro_off     (w_cpu_ro),
        .o_misaligned (w_cpu_misal_unused)
    );

    bridge_arbiter_decode #(.NDEV(NDEV), .DEV_BASE(DEV_BASE)) u_m2_dec (
        .i_addr       (bus.m2_addr),
        .o_hit        (w_m2_hit),
        .o_ro_off     (w_m2_ro),
        .o_misaligned (w_m2_misal)
    );

    // Only CPU accesses that land in a device window contend for the bus.
    assign w_cpu_active = (bus.cpu_we | bus.cpu_re) & (|w_cpu_hit);
    assign w_m2_bad     = w_m2_misal | ~(|w_m2_hit) | (bus.m2_we & w_m2_ro);

    always_comb begin
        w_cpu_rd  = '0;
        w_hold_rd = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (w_cpu_hit[i]) begin
                w_cpu_rd = bus.dev_rd[32*i +: 32];
            end
            if (r_hold_hit[i]) begin
                w_hold_rd = bus.dev_rd[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_dev_addr = '0;
        w_dev_wd   = '0;
        w_dev_we   = '0;
        if (w_cpu_active) begin
            w_dev_addr = bus.cpu_addr;
            w_dev_wd   = bus.cpu_wd;
            w_dev_we   = (bus.cpu_we && !w_cpu_ro) ? w_cpu_hit : '0;
        end else if (r_state == ST_PEND) begin
            w_dev_addr = r_hold_addr;
            w_dev_wd   = r_hold_wd;
            w_dev_we   = r_hold_we ? r_hold_hit : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_hold_addr <= '0;
            r_hold_wd   <= '0;
            r_hold_we   <= 1'b0;
            r_hold_hit  <= '0;
            r_cnt       <= '0;
            r_starve    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.m2_valid && r_ready) begin
                        r_ready <= 1'b0;
                        if (w_m2_bad) begin
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                            r_state  <= ST_RESP;
                        end else begin
                            r_hold_addr <= bus.m2_addr;
                            r_hold_wd   <= bus.m2_wd;
                            r_hold_we   <= bus.m2_we;
                            r_hold_hit  <= w_m2_hit;
                            r_state     <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (w_cpu_active) begin
                        if (r_cnt != LIMIT) begin
                            r_cnt    <= r_cnt + CW'(1);
                            r_starve <= ((r_cnt + CW'(1)) == LIMIT);
                        end
                    end else begin
                        if (!r_hold_we) begin
                            r_rdata <= w_hold_rd;
                        end
                        r_cnt    <= '0;
                        r_starve <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b0;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rd    = w_cpu_rd;
    assign bus.dev_addr  = w_dev_addr;
    assign bus.dev_wd    = w_dev_wd;
    assign bus.dev_we    = w_dev_we;
    assign bus.m2_ready  = r_ready;
    assign bus.m2_rvalid = r_rvalid;
    assign bus.m2_rdata  = r_rdata;
    assign bus.m2_err    = r_err;
    assign bus.starve    = r_starve;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all continuously checked against a transaction-level model.
module tb_bridge_arbiter;

    localparam int          NDEV  = 2;
    localparam logic [31:0] BASE  = 32'h0000_7F00;
    localparam int          SLIM  = 16;

    logic clk;
    logic rst;

    bridge_arbiter_if #(.NDEV(NDEV)) bus ();

    bridge_arbiter #(.NDEV(NDEV), .DEV_BASE(BASE), .STARVE_LIMIT(SLIM)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Window index of an address, or -1 if it falls in no device window.
    function automatic int win_idx(input logic [31:0] a);
        logic [31:0] off;
        if (a < BASE) return -1;
        off = a - BASE;
        if (off >= 32'(NDEV * 16)) return -1;
        if ((off % 16) >= 12) return -1;
        return int'(off / 16);
    endfunction

    function automatic bit win_ro(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off % 16) >= 8;
    endfunction

    // ---------------- transaction-level model ----------------
    bit          m_out;      // a request is held, waiting for the bus
    bit          m_resp;     // response is presented this cycle
    bit          m_rerr;
    bit          m_rread;
    logic [31:0] m_rdata;
    int          m_blk;
    logic [31:0] m_addr, m_wd;
    bit          m_we;
    int          m_idx;

    always @(negedge clk) begin
        int          ci;
        bit          cact;
        logic [31:0] e_cpu_rd, e_addr, e_wd;
        logic [NDEV-1:0] e_we;
        int          ri;
        bit          bad;

        if (rst) begin
            m_out = 0; m_resp = 0; m_rerr = 0; m_rread = 0;
            m_rdata = '0; m_blk = 0; m_addr = '0; m_wd = '0; m_we = 0; m_idx = 0;
        end

        ci   = win_idx(bus.cpu_addr);
        cact = (bus.cpu_we || bus.cpu_re) && (ci >= 0);
        e_cpu_rd = (ci >= 0) ? bus.dev_rd[32*ci +: 32] : 32'h0;

        e_addr = '0; e_wd = '0; e_we = '0;
        if (cact) begin
            e_addr = bus.cpu_addr;
            e_wd   = bus.cpu_wd;
            if (bus.cpu_we && !win_ro(bus.cpu_addr)) e_we = NDEV'(1) << ci;
        end else if (m_out) begin
            e_addr = m_addr;
            e_wd   = m_wd;
            if (m_we) e_we = NDEV'(1) << m_idx;
        end

        check("cpu_rd",    {32'h0, bus.cpu_rd},   {32'h0, e_cpu_rd});
        check("dev_addr",  {32'h0, bus.dev_addr}, {32'h0, e_addr});
        check("dev_wd",    {32'h0, bus.dev_wd},   {32'h0, e_wd});
        check("dev_we",    64'(bus.dev_we),       64'(e_we));
        check("m2_ready",  64'(bus.m2_ready),     64'(!m_out && !m_resp));
        check("m2_rvalid", 64'(bus.m2_rvalid),    64'(m_resp));
        check("m2_err",    64'(bus.m2_err),       64'(m_resp && m_rerr));
        check("starve",    64'(bus.starve),       64'(m_out && m_blk >= SLIM));
        if (m_resp && m_rread && !m_rerr)
            check("m2_rdata", {32'h0, bus.m2_rdata}, {32'h0, m_rdata});

        if (!rst) begin
            if (m_resp) begin
                m_resp = 0;
            end else if (m_out) begin
                if (cact) begin
                    if (m_blk < SLIM) m_blk++;
                end else begin
                    m_out = 0; m_resp = 1; m_rerr = 0; m_rread = !m_we; m_blk = 0;
                    if (!m_we) m_rdata = bus.dev_rd[32*m_idx +: 32];
                end
            end else if (bus.m2_valid) begin
                ri  = win_idx(bus.m2_addr);
                bad = (bus.m2_addr[1:0] != 2'b00) || (ri < 0) ||
                      (bus.m2_we && win_ro(bus.m2_addr));
                if (bad) begin
                    m_resp = 1; m_rerr = 1; m_rread = 0;
                end else begin
                    m_out = 1; m_addr = bus.m2_addr; m_wd = bus.m2_wd;
                    m_we = bus.m2_we; m_idx = ri; m_blk = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #5;
    endtask

    task automatic idle_inputs();
        bus.cpu_we = 0; bus.cpu_re = 0; bus.cpu_addr = '0; bus.cpu_wd = '0;
        bus.m2_valid = 0; bus.m2_addr = '0; bus.m2_wd = '0; bus.m2_we = 0;
    endtask

    task automatic m2_req(input logic [31:0] a, input logic [31:0] d, input logic we);
        bus.m2_valid = 1; bus.m2_addr = a; bus.m2_wd = d; bus.m2_we = we;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom % 8;
        if (r < 4) return BASE + 32'(($urandom % 3) * 16) + 32'(($urandom % 3) * 4);
        if (r < 6) return BASE + 32'(($urandom % 3) * 16) + 32'($urandom % 16);
        if (r == 6) return 32'h0000_1000 + 32'(($urandom % 16) * 4);
        return $urandom;
    endfunction

    logic [31:0] err_addrs [3];

    initial begin
        rst = 1;
        idle_inputs();
        bus.dev_rd = {32'hDEAD_BEEF, 32'h1111_1111};

        // 1: reset for three cycles, then release
        repeat (3) tick();
        rst = 0;
        probe();
        check("t1_ready",  64'(bus.m2_ready), 64'd1);
        check("t1_rvalid", 64'(bus.m2_rvalid), 64'd0);
        check("t1_starve", 64'(bus.starve), 64'd0);
        check("t1_dev_we", 64'(bus.dev_we), 64'd0);
        check("t1_cpu_rd", {32'h0, bus.cpu_rd}, 64'd0);

        // 2: m2 read of device 1 word 1 on a free bus
        tick(); m2_req(32'h7F14, 32'h0, 0);
        tick(); idle_inputs();
        probe(); check("t2_rvalid_early", 64'(bus.m2_rvalid), 64'd0);
        tick(); probe();
        check("t2_rvalid", 64'(bus.m2_rvalid), 64'd1);
        check("t2_rdata",  {32'h0, bus.m2_rdata}, 64'hDEAD_BEEF);
        check("t2_err",    64'(bus.m2_err), 64'd0);
        tick();

        // 3: m2 write held off one cycle by a CPU store
        tick(); m2_req(32'h7F10, 32'h5, 1);
        tick(); idle_inputs();
        bus.cpu_we = 1; bus.cpu_addr = 32'h7F04; bus.cpu_wd = 32'h9;
        probe();
        check("t3_cpu_we", 64'(bus.dev_we), 64'b01);
        check("t3_cpu_wd", {32'h0, bus.dev_wd}, 64'h9);
        tick(); idle_inputs(); probe();
        check("t3_m2_we",   64'(bus.dev_we), 64'b10);
        check("t3_m2_wd",   {32'h0, bus.dev_wd}, 64'h5);
        check("t3_m2_addr", {32'h0, bus.dev_addr}, 64'h7F10);
        tick(); probe();
        check("t3_rvalid", 64'(bus.m2_rvalid), 64'd1);
        check("t3_err",    64'(bus.m2_err), 64'd0);
        tick();

        // 4: bad requests: write to read-only word, misaligned, no window
        err_addrs[0] = 32'h7F08; err_addrs[1] = 32'h7F02; err_addrs[2] = 32'h7F40;
        for (int k = 0; k < 3; k++) begin
            tick(); m2_req(err_addrs[k], 32'hA5A5_A5A5, (k == 0));
            probe(); check("t4_dev_we_req", 64'(bus.dev_we), 64'd0);
            tick(); idle_inputs(); probe();
            check("t4_rvalid", 64'(bus.m2_rvalid), 64'd1);
            check("t4_err",    64'(bus.m2_err), 64'd1);
            check("t4_dev_we", 64'(bus.dev_we), 64'd0);
        end
        tick();

        // 5: CPU loads from device 0 every cycle for 20 cycles
        tick(); m2_req(32'h7F00, 32'h0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick(); idle_inputs();
            bus.cpu_re = 1; bus.cpu_addr = 32'h7F00;
            probe();
            if (k == 1)  check("t5_cpu_rd", {32'h0, bus.cpu_rd}, 64'h1111_1111);
            if (k == 16) check("t5_starve_16", 64'(bus.starve), 64'd0);
            if (k == 17) check("t5_starve_17", 64'(bus.starve), 64'd1);
            if (k == 20) check("t5_starve_20", 64'(bus.starve), 64'd1);
        end
        tick(); idle_inputs(); probe();
        check("t5_issue_addr", {32'h0, bus.dev_addr}, 64'h7F00);
        check("t5_rvalid_pre", 64'(bus.m2_rvalid), 64'd0);
        tick(); probe();
        check("t5_rvalid",     64'(bus.m2_rvalid), 64'd1);
        check("t5_rdata",      {32'h0, bus.m2_rdata}, 64'h1111_1111);
        check("t5_starve_end", 64'(bus.starve), 64'd0);
        tick();

        // 6: reset while a write is pending
        tick(); m2_req(32'h7F04, 32'h77, 1);
        tick(); idle_inputs(); rst = 1; probe();
        check("t6_ready_rst",  64'(bus.m2_ready), 64'd1);
        check("t6_dev_we_rst", 64'(bus.dev_we), 64'd0);
        tick(); rst = 0; probe();
        check("t6_rvalid_a", 64'(bus.m2_rvalid), 64'd0);
        check("t6_dev_we_a", 64'(bus.dev_we), 64'd0);
        tick(); probe();
        check("t6_rvalid_b", 64'(bus.m2_rvalid), 64'd0);
        tick(); m2_req(32'h7F14, 32'h0, 0);
        tick(); idle_inputs();
        tick(); probe();
        check("t6_rvalid_new", 64'(bus.m2_rvalid), 64'd1);
        check("t6_rdata_new",  {32'h0, bus.m2_rdata}, 64'hDEAD_BEEF);
        tick();

        // Randomized traffic with periodic CPU bursts to provoke starvation
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = ($urandom % 400 == 0);
            bus.dev_rd   = {$urandom, $urandom};
            bus.cpu_addr = rand_addr();
            bus.cpu_wd   = $urandom;
            bus.cpu_we   = ($urandom % 4 == 0);
            bus.cpu_re   = ($urandom % 4 == 0);
            if ((c % 600) >= 570) begin
                bus.cpu_re   = 1;
                bus.cpu_addr = BASE + 32'(($urandom % 2) * 16);
            end
            bus.m2_valid = ($urandom % 2 == 0);
            bus.m2_addr  = rand_addr();
            bus.m2_wd    = $urandom;
            bus.m2_we    = ($urandom % 2 == 0);
        end
        tick(); rst = 0; idle_inputs();
        repeat (3) tick();
        probe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
